qos_fuente: RTL and testbench

Four-channel traffic source on the write side of the QoS FIFO bank, the other end of the QoS flow-control interface. Each cycle it pushes at most one word into one of four FIFOs, chosen by round-robin, and obeys the per-channel `pausa`/`continuar` commands and the `error`/`idle` status issued by the QoS block. It stops cleanly after a fixed per-channel word budget.

---
 rtl/qos_fuente.sv | 163 ++++++++++++++++
 tb/tb_qos_fuente.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_fuente.sv
// qos_fuente: four-channel round-robin traffic source feeding the QoS FIFO bank.
// Each cycle it pushes at most one word, honours per-channel pause/resume
// commands and the QoS error/idle status, and stops after PALABRAS words per
// channel.
module qos_fuente #(
  parameter int DATA_WIDTH = 6,
  parameter int PALABRAS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  iniciar_in,
  input  logic [3:0]            pausa_in,
  input  logic [3:0]            continuar_in,
  input  logic                  error_in,
  input  logic                  idle_in,
  output logic [3:0]            push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [3:0]            pausado_out,
  output logic                  activo_out,
  output logic                  fin_out,
  output logic                  error_out
);

  localparam int         SW   = DATA_WIDTH - 2;
  localparam logic [7:0] PAL8 = 8'(PALABRAS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVO,
    S_DRENAR,
    S_FIN,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            p_q, p_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [7:0]            cnt_q [4];
  logic [7:0]            cnt_d [4];
  logic [SW-1:0]         seq_q [4];
  logic [SW-1:0]         seq_d [4];
  logic [3:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [3:0] elig;
  logic       found;
  logic [1:0] sel;
  logic [1:0] cand;
  logic       all_done;

  // Pause register: pause wins over resume when both arrive together.
  always_comb begin
    p_d = (p_q & ~continuar_in) | pausa_in;
  end

  // Eligibility uses this cycle's pause view so a pause takes effect with no bubble.
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      elig[i] = ~p_d[i] && (cnt_q[i] < PAL8);
      if (cnt_q[i] != PAL8) all_done = 1'b0;
    end
  end

  // Round-robin pick: first eligible channel after the last one served.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state, counters and push generation; enb low freezes everything but pauses.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    push_d  = '0;
    data_d  = data_q;
    if (enb) begin
      unique case (state_q)
        S_IDLE: begin
          if (iniciar_in) begin
            state_d = S_ACTIVO;
            ptr_d   = 2'd3;
            for (int i = 0; i < 4; i++) begin
              cnt_d[i] = '0;
              seq_d[i] = '0;
            end
          end
        end
        S_ACTIVO: begin
          if (error_in)        state_d = S_ERROR;
          else if (all_done)   state_d = S_DRENAR;
          else if (!iniciar_in) state_d = S_IDLE;
          else if (found) begin
            push_d     = 4'b0001 << sel;
            data_d     = {sel, seq_q[sel]};
            seq_d[sel] = seq_q[sel] + SW'(1);
            cnt_d[sel] = cnt_q[sel] + 8'd1;
            ptr_d      = sel;
          end
        end
        S_DRENAR: begin
          if (error_in)     state_d = S_ERROR;
          else if (idle_in) state_d = S_FIN;
        end
        S_FIN: begin
          if (error_in)         state_d = S_ERROR;
          else if (!iniciar_in) state_d = S_IDLE;
        end
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers, including the small per-channel tables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q    <= '0;
      ptr_q  <= 2'd3;
      push_q <= '0;
      data_q <= '0;
      // NOTE: the per-channel tables are only four entries, so they are reset like plain registers.
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        seq_q[i] <= '0;
      end
    end else begin
      p_q    <= p_d;
      ptr_q  <= ptr_d;
      push_q <= push_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
    end
  end

  assign push_out    = push_q;
  assign data_out    = data_q;
  assign pausado_out = p_q;
  assign activo_out  = (state_q == S_ACTIVO);
  assign fin_out     = (state_q == S_FIN);
  assign error_out   = (state_q == S_ERROR);

endmodule

// File: tb/tb_qos_fuente.sv
// Bench for qos_fuente: two instances (6-bit/8 words and 4-bit/6 words) share
// stimulus; a behavioural model predicts each instance's outputs every cycle.
module tb_qos_fuente;

  localparam int M_IDLE = 0, M_ACT = 1, M_DRN = 2, M_FIN = 3, M_ERR = 4;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       iniciar;
  logic [3:0] pausa;
  logic [3:0] cont;
  logic       err;
  logic       idl;

  logic [3:0] push0, paus0, push1, paus1;
  logic [5:0] data0;
  logic [3:0] data1;
  logic       act0, fin0, erro0, act1, fin1, erro1;

  qos_fuente u0 (
    .clk(clk), .rst(rst), .enb(enb), .iniciar_in(iniciar), .pausa_in(pausa),
    .continuar_in(cont), .error_in(err), .idle_in(idl), .push_out(push0),
    .data_out(data0), .pausado_out(paus0), .activo_out(act0), .fin_out(fin0),
    .error_out(erro0)
  );

  qos_fuente #(.DATA_WIDTH(4), .PALABRAS(6)) u1 (
    .clk(clk), .rst(rst), .enb(enb), .iniciar_in(iniciar), .pausa_in(pausa),
    .continuar_in(cont), .error_in(err), .idle_in(idl), .push_out(push1),
    .data_out(data1), .pausado_out(paus1), .activo_out(act1), .fin_out(fin1),
    .error_out(erro1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state per instance.
  int       dw_a [2];
  int       pal_a [2];
  int       m_mode [2];
  bit [3:0] m_p [2];
  int       m_cnt [2][4];
  int       m_seq [2][4];
  int       m_last [2];
  bit [3:0] m_push [2];
  int       m_data [2];
  int       obs_cnt [2][4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = M_IDLE;
      m_p[u]    = '0;
      m_last[u] = 3;
      m_push[u] = '0;
      m_data[u] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[u][i] = 0;
        m_seq[u][i] = 0;
      end
    end
  endtask

  task automatic clr_obs();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) obs_cnt[u][i] = 0;
  endtask

  // One clock of behaviour for instance u, using the inputs currently driven.
  task automatic step_model(input int u);
    bit [3:0] pn;
    bit       done;
    int       c;
    for (int i = 0; i < 4; i++) begin
      if (pausa[i])     pn[i] = 1'b1;
      else if (cont[i]) pn[i] = 1'b0;
      else              pn[i] = m_p[u][i];
    end
    m_p[u]    = pn;
    m_push[u] = '0;
    if (!enb) return;
    done = 1'b1;
    for (int i = 0; i < 4; i++) if (m_cnt[u][i] != pal_a[u]) done = 1'b0;
    case (m_mode[u])
      M_IDLE: if (iniciar) begin
        m_mode[u] = M_ACT;
        m_last[u] = 3;
        for (int i = 0; i < 4; i++) begin
          m_cnt[u][i] = 0;
          m_seq[u][i] = 0;
        end
      end
      M_ACT: begin
        if (err)           m_mode[u] = M_ERR;
        else if (done)     m_mode[u] = M_DRN;
        else if (!iniciar) m_mode[u] = M_IDLE;
        else begin
          for (int k = 1; k <= 4; k++) begin
            c = (m_last[u] + k) % 4;
            if (m_push[u] == 0 && !pn[c] && m_cnt[u][c] < pal_a[u]) begin
              m_push[u]    = 4'(1 << c);
              m_data[u]    = c * (1 << (dw_a[u] - 2)) + m_seq[u][c];
              m_seq[u][c]  = (m_seq[u][c] + 1) % (1 << (dw_a[u] - 2));
              m_cnt[u][c]  = m_cnt[u][c] + 1;
              m_last[u]    = c;
            end
          end
        end
      end
      M_DRN: begin
        if (err)      m_mode[u] = M_ERR;
        else if (idl) m_mode[u] = M_FIN;
      end
      M_FIN: begin
        if (err)           m_mode[u] = M_ERR;
        else if (!iniciar) m_mode[u] = M_IDLE;
      end
      default: m_mode[u] = M_ERR;
    endcase
  endtask

  task automatic compare_all();
    logic [3:0]  op, opa;
    logic [31:0] od;
    logic        oa, of, oe;
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin
        op = push0; od = 32'(data0); opa = paus0; oa = act0; of = fin0; oe = erro0;
      end else begin
        op = push1; od = 32'(data1); opa = paus1; oa = act1; of = fin1; oe = erro1;
      end
      check($sformatf("u%0d push", u), 32'(op), 32'(m_push[u]));
      check($sformatf("u%0d data", u), od, m_data[u]);
      check($sformatf("u%0d pausado", u), 32'(opa), 32'(m_p[u]));
      check($sformatf("u%0d activo", u), 32'(oa), 32'(m_mode[u] == M_ACT));
      check($sformatf("u%0d fin", u), 32'(of), 32'(m_mode[u] == M_FIN));
      check($sformatf("u%0d error", u), 32'(oe), 32'(m_mode[u] == M_ERR));
      for (int i = 0; i < 4; i++) if (op[i]) obs_cnt[u][i]++;
    end
  endtask

  task automatic drive(input bit ini, input bit [3:0] pa, input bit [3:0] co,
                       input bit er, input bit id, input bit en);
    iniciar = ini; pausa = pa; cont = co; err = er; idl = id; enb = en;
  endtask

  // Compare the previous cycle's prediction, then apply new inputs and predict.
  task automatic tick(input bit ini, input bit [3:0] pa, input bit [3:0] co,
                      input bit er, input bit id, input bit en);
    @(negedge clk);
    compare_all();
    drive(ini, pa, co, er, id, en);
    step_model(0);
    step_model(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    step_model(0);
    step_model(1);
  endtask

  int snap;
  int tot;

  initial begin
    dw_a[0] = 6; pal_a[0] = 8;
    dw_a[1] = 4; pal_a[1] = 6;
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    model_reset();
    clr_obs();

    // Full run without pauses, then drain to FIN.
    do_reset();
    clr_obs();
    tick(1, 0, 0, 0, 0, 1);
    repeat (40) tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1, 1);
    tick(1, 0, 0, 0, 1, 1);
    check("fin_after_drain", 32'(fin0), 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u0 total ch%0d", i), obs_cnt[0][i], 8);
      check($sformatf("u1 total ch%0d", i), obs_cnt[1][i], 6);
    end
    tick(0, 0, 0, 0, 0, 1);

    // Channel 1 paused for a window, then resumed.
    do_reset();
    clr_obs();
    tick(1, 0, 0, 0, 0, 1);
    repeat (5) tick(1, 0, 0, 0, 0, 1);
    tick(1, 4'b0010, 0, 0, 0, 1);
    snap = obs_cnt[0][1];
    repeat (8) tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 4'b0010, 0, 0, 1);
    check("ch1 silent while paused", obs_cnt[0][1], snap);
    repeat (30) tick(1, 0, 0, 0, 0, 1);
    tot = 0;
    for (int i = 0; i < 4; i++) tot += obs_cnt[0][i];
    check("pause run total", tot, 32);

    // Pause and resume together on channel 3: pause wins.
    do_reset();
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 4'b1000, 4'b1000, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    check("ch3 paused", 32'(paus0[3]), 1);
    repeat (6) tick(1, 0, 0, 0, 0, 1);

    // Drop iniciar after 10 pushes, then restart from scratch.
    do_reset();
    tick(1, 0, 0, 0, 0, 1);
    repeat (10) tick(1, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    check("idle after drop", 32'(act0), 0);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    check("restart push", 32'(push0), 1);
    check("restart data", 32'(data0), 0);

    // Asynchronous reset in the middle of a run.
    repeat (4) tick(1, 0, 0, 0, 0, 1);
    do_reset();

    // error_in in IDLE is ignored; mid-run it is sticky until reset.
    tick(0, 0, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    repeat (6) tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 1, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    snap = obs_cnt[0][0] + obs_cnt[0][1] + obs_cnt[0][2] + obs_cnt[0][3];
    repeat (10) tick(1, 0, 0, 0, 1, 1);
    check("error sticky", 32'(erro0), 1);
    check("no pushes in error",
          obs_cnt[0][0] + obs_cnt[0][1] + obs_cnt[0][2] + obs_cnt[0][3], snap);
    do_reset();
    check("error cleared by reset", 32'(erro0), 0);

    // Randomised traffic: sparse pauses/resumes, enb gaps, occasional aborts.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit       ini, id, en;
      bit [3:0] pa, co;
      for (int i = 0; i < 4; i++) begin
        pa[i] = ($urandom_range(0, 15) == 0);
        co[i] = ($urandom_range(0, 5) == 0);
      end
      if (m_mode[0] == M_FIN || m_mode[1] == M_FIN) ini = ($urandom_range(0, 3) != 0);
      else                                          ini = ($urandom_range(0, 149) != 0);
      id = $urandom_range(0, 1);
      en = ($urandom_range(0, 9) != 0);
      tick(ini, pa, co, 0, id, en);
    end
    tick(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
